bp_be_fe_queue_rolly: RTL

Rollback-capable FIFO between the front end and the back end. It holds fetched instructions in order, and the back end's checker reads them speculatively. Entries are kept until the checker commits them with `fe_queue_deq`. On an exception the checker can rewind with `fe_queue_roll`, and on a flush it discards unread entries with `fe_queue_clr`. The block drives the back end's `fe_queue_i` / `fe_queue_v_i` and consumes its `fe_queue_yumi_o`, `fe_queue_deq_o`, `fe_queue_roll_o` and `fe_queue_clr_o`.

---
 rtl/bp_be_fe_queue_rolly_pkg.sv | 33 +++
 rtl/bp_be_fe_queue_rolly_ptr.sv | 32 +++
 rtl/bp_be_fe_queue_rolly.sv | 100 ++++++++++
 3 files changed

// File: rtl/bp_be_fe_queue_rolly_pkg.sv
// Shared back-end definitions: front-end queue entry layout, config selector
// and the clear/roll action encoding used by the rollback queue.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_bp_inv_cfg     = 2'd0,
    e_bp_default_cfg = 2'd1
  } bp_params_e;

  typedef struct packed {
    logic [1:0]  msg_type;
    logic [38:0] pc;
    logic [31:0] instr;
  } bp_fe_queue_s;

  // Roll always wins on rptr; clear retargets wptr to wherever rptr lands,
  // so clear+roll empties the queue down to the commit pointer.
  typedef enum logic [1:0] {
    e_fe_queue_none     = 2'b00,
    e_fe_queue_roll     = 2'b01,
    e_fe_queue_clr      = 2'b10,
    e_fe_queue_clr_roll = 2'b11
  } bp_be_fe_queue_clr_roll_e;

  function automatic int fe_queue_width(input bp_params_e cfg);
    case (cfg)
      e_bp_inv_cfg:     return $bits(bp_fe_queue_s);
      e_bp_default_cfg: return $bits(bp_fe_queue_s);
      default:          return $bits(bp_fe_queue_s);
    endcase
  endfunction

endpackage

// File: rtl/bp_be_fe_queue_rolly_ptr.sv
// Wrapping pointer register with increment and synchronous load; load wins.
module bp_be_rolly_ptr #(
  parameter int width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               inc_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  output logic [width_p-1:0] ptr_o
);

  logic [width_p-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i)
      ptr_d = load_val_i;
    else if (inc_i)
      ptr_d = ptr_q + width_p'(1);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/bp_be_fe_queue_rolly.sv
// Rollback-capable FE->BE queue: speculative read pointer, separate commit
// pointer, rewind to commit on roll and discard of unread entries on clear.
module bp_be_fe_queue_rolly
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_inv_cfg,
  parameter int         els_p       = 8,
  localparam int fe_queue_width_lp = fe_queue_width(bp_params_p),
  localparam int addr_width_lp     = $clog2(els_p),
  localparam int ptr_width_lp      = $clog2(els_p) + 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [fe_queue_width_lp-1:0] fe_queue_i,
  input  logic                         fe_queue_v_i,
  output logic                         fe_queue_ready_o,
  output logic [fe_queue_width_lp-1:0] fe_queue_o,
  output logic                         fe_queue_v_o,
  input  logic                         fe_queue_yumi_i,
  input  logic                         fe_queue_deq_i,
  input  logic                         fe_queue_roll_i,
  input  logic                         fe_queue_clr_i
);

  logic [ptr_width_lp-1:0] wptr, rptr, cptr;
  logic [ptr_width_lp-1:0] cptr_d, rptr_d;
  logic [ptr_width_lp-1:0] occupancy;
  logic                    full, enq_v;
  logic                    rptr_load, wptr_load;
  bp_be_fe_queue_clr_roll_e clr_roll;

  logic [fe_queue_width_lp-1:0] mem_q [els_p];

  assign occupancy = wptr - cptr;
  assign full      = (occupancy == ptr_width_lp'(els_p));
  assign enq_v     = fe_queue_v_i & fe_queue_ready_o & ~fe_queue_clr_i;

  assign clr_roll = bp_be_fe_queue_clr_roll_e'({fe_queue_clr_i, fe_queue_roll_i});

  always_comb begin
    rptr_load = 1'b0;
    wptr_load = 1'b0;
    case (clr_roll)
      e_fe_queue_roll:     rptr_load = 1'b1;
      e_fe_queue_clr:      wptr_load = 1'b1;
      e_fe_queue_clr_roll: begin
        rptr_load = 1'b1;
        wptr_load = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state views let deq+roll and clr+yumi resolve against the updated pointer.
  assign cptr_d = cptr + ptr_width_lp'(fe_queue_deq_i);
  assign rptr_d = rptr_load ? cptr_d : (rptr + ptr_width_lp'(fe_queue_yumi_i));

  bp_be_rolly_ptr #(.width_p(ptr_width_lp)) u_wptr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .inc_i      (enq_v),
    .load_i     (wptr_load),
    .load_val_i (rptr_d),
    .ptr_o      (wptr)
  );

  bp_be_rolly_ptr #(.width_p(ptr_width_lp)) u_rptr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .inc_i      (fe_queue_yumi_i & ~fe_queue_roll_i),
    .load_i     (rptr_load),
    .load_val_i (cptr_d),
    .ptr_o      (rptr)
  );

  bp_be_rolly_ptr #(.width_p(ptr_width_lp)) u_cptr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .inc_i      (fe_queue_deq_i),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (cptr)
  );

  always_ff @(posedge clk_i) begin
    if (enq_v)
      mem_q[wptr[addr_width_lp-1:0]] <= fe_queue_i;
  end

  assign fe_queue_o       = mem_q[rptr[addr_width_lp-1:0]];
  assign fe_queue_v_o     = (rptr != wptr);
  assign fe_queue_ready_o = reset_i & ~full;

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_i)
    fe_queue_yumi_i |-> fe_queue_v_o);

  a_deq_needs_read: assert property (@(posedge clk_i) disable iff (!reset_i)
    fe_queue_deq_i |-> (cptr != rptr));

endmodule
